rf_wb_ctrl: RTL

Writeback controller that drives the register file write port (dst_addr/dst/we). It merges single-cycle ALU results with long-latency results from the load and mul/div units. Long-latency results pass through a 2-entry FIFO. A 32-bit scoreboard of pending destinations lets decode stall on RAW hazards. It sits between the execute/memory units and rf.

---
 rtl/rf_wb_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// rf_wb_ctrl
//
// Writeback controller for the register file write port. It merges
// single-cycle ALU results with long-latency results from the load and
// mul/div units. Long-latency results are buffered in a small FIFO. A
// scoreboard of pending destinations lets decode detect RAW hazards.
//
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   alu_valid/rd/data      ALU result; always accepted, has priority
//   ll_valid/rd/data       long-latency result; accepted when ll_ready
//   ll_ready               FIFO has room (from registered count only)
//   iss_valid/rd           long-latency op issued; marks iss_rd pending
//   rs1_addr, rs2_addr     decode source registers
//   rs1_busy, rs2_busy     source is pending in the scoreboard
//   wb_we/addr/data        registered register file write port
//   err_waw                sticky: ALU wrote a register that was pending
// ---------------------------------------------------------------------------
module rf_wb_ctrl #(
    parameter  int DW         = 32,
    parameter  int NREG       = 32,
    parameter  int FIFO_DEPTH = 2,
    localparam int AW         = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,

    input  logic          ll_valid,
    output logic          ll_ready,
    input  logic [AW-1:0] ll_rd,
    input  logic [DW-1:0] ll_data,

    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,

    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,

    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          err_waw
);

    // Pointer width covers the storage index; the count needs one extra
    // bit so that "full" (count == FIFO_DEPTH) is representable.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [AW-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [NREG-1:0] busy;

    // -----------------------------------------------------------------------
    // Next-cycle decisions
    // -----------------------------------------------------------------------
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          ll_clear;
    logic          waw_hit;
    logic [NREG-1:0] busy_next;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // ll_ready looks only at the registered count, so a producer never sees
    // ready depend on whether the ALU happens to block a pop this cycle.
    assign ll_ready = !fifo_full;
    assign push     = ll_valid && ll_ready;

    // The FIFO only drains in cycles the ALU leaves the write port free.
    assign pop      = !alu_valid && !fifo_empty;

    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

    // Select the result for the write port. Destination x0 is never written,
    // but a popped x0 entry is still consumed from the FIFO.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = alu_rd;
        sel_data = alu_data;
        ll_clear = 1'b0;
        if (alu_valid) begin
            sel_we   = (alu_rd != '0);
            sel_addr = alu_rd;
            sel_data = alu_data;
        end else if (pop) begin
            sel_we   = (head_rd != '0);
            sel_addr = head_rd;
            sel_data = head_data;
            ll_clear = (head_rd != '0);
        end
    end

    // An ALU write to a register still owed by a long-latency unit is a
    // write-after-write ordering bug upstream; flag it but let it through.
    assign waw_hit = alu_valid && (alu_rd != '0) && busy[alu_rd];

    // Scoreboard update: clear first, then set, so a same-cycle issue to the
    // register being retired leaves it pending. x0 is forced clear.
    always_comb begin
        busy_next = busy;
        if (ll_clear) begin
            busy_next[head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // -----------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the count alone says what is
    // valid, and reset empties the FIFO by clearing count and pointers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ll_rd;
            fifo_data[wr_ptr] <= ll_data;
        end
    end

    // FIFO pointers and occupancy. Depth is a power of two so the pointers
    // wrap naturally at the top of their range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Registered write port. Address and data hold their last written values
    // when nothing is written, so only wb_we pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= sel_we;
            if (sel_we) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    // Sticky write-after-write error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_waw <= 1'b0;
        end else if (waw_hit) begin
            err_waw <= 1'b1;
        end
    end

endmodule
